mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Pipeline stage directly downstream of execute. Registers the execute results (ALU result, address,
//  store data) into the EX/MEM register. Runs loads and stores on the data-memory port with a req/ack
//  handshake and stalls the front of the pipeline until the access completes. Produces the MEM/WB
//  register for writeback. Also drives M_exeOut, the memory-stage forwarding source fed back to execute.
// PARAMETERS
//  TIMEOUT    256   max cycles mem_req may wait for mem_ack before the access is aborted with mem_err
//  RD_W       5     width of destination-register index
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous reset, active-high
//  ex_valid     in   1   execute holds a valid instruction this cycle
//  exeOut       in   32  ALU result from execute
//  addrOut      in   32  memory address from execute (SP or ALU result)
//  RegData1_o   in   32  forwarded store data from execute
//  ex_rd        in   5   destination register
//  ex_regwrite  in   1   instruction writes a register
//  ex_memread   in   1   load
//  ex_memwrite  in   1   store (memread and memwrite both set: treated as load, store ignored)
//  mem_req      out  1   data-memory request
//  mem_we       out  1   1 = write, 0 = read; valid while mem_req
//  mem_addr     out  32  word address; valid while mem_req
//  mem_wdata    out  32  store data; valid while mem_req
//  mem_ack      in   1   memory completed the access; mem_rdata valid in the same cycle
//  mem_rdata    in   32  load data
//  stall        out  1   hold PC, IF, ID and EX stages (combinational)
//  M_exeOut     out  32  EX/MEM ALU result, for forwarding to execute
//  M_rd         out  5   EX/MEM rd, for forwarding compare
//  M_regwrite   out  1   EX/MEM regwrite qualified by EX/MEM valid
//  wb_valid     out  1   MEM/WB holds a valid instruction
//  wb_data      out  32  load data or ALU result
//  wb_rd        out  5   MEM/WB destination register
//  wb_regwrite  out  1   write enable to the register file
//  mem_err      out  1   sticky: misaligned access or timeout; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; EX/MEM and MEM/WB valid = 0; FSM = IDLE; timeout counter = 0.
//  EX/MEM loads the ex_* inputs on every posedge where stall = 0; it holds while stall = 1.
//  FSM states:
//   IDLE: if EX/MEM is valid and memread/memwrite is set, go to REQ. stall = 1 in that same cycle.
//   REQ: mem_req = 1 and mem_addr, mem_we, mem_wdata held constant; count each cycle.
//    mem_ack = 1 -> DONE; load captures mem_rdata.
//    count reaches TIMEOUT-1 without ack -> set mem_err, drop mem_req, go to DONE (op squashed).
//   DONE: stall = 0 for one cycle; MEM/WB is written; go to IDLE.
//  Stall and request timing:
//   stall = 1 in IDLE-with-mem-op and in REQ, including the cycle where mem_ack arrives.
//   A memory op therefore costs 1 + N_wait + 1 cycles in this stage.
//   mem_req drops the cycle after ack. Back-to-back mem ops re-enter REQ after one IDLE cycle.
//  Non-memory op: MEM/WB is written the cycle after EX/MEM; no stall. Latency = 1 cycle.
//  MEM/WB on load: wb_data = captured rdata. On any other op: wb_data = ALU result.
//   wb_regwrite = regwrite & valid & ~squashed.
//   While stall = 1, MEM/WB loads a bubble (wb_valid = 0).
//  Misaligned access (addrOut[1:0] != 0 on a mem op): no request is issued; mem_err is set;
//   the op goes to DONE as squashed, with wb_regwrite = 0.
//  M_exeOut, M_rd and M_regwrite always reflect EX/MEM, including during a stall.
//  A store to rd 0 or a write to rd 0 passes through unchanged; regfile handles x0.
//  rst while in REQ: mem_req drops next cycle; no ack is tracked afterwards.
//   The memory model must tolerate an abandoned request.
// TESTING
//  ALU op, exeOut=0x1234, rd=3, regwrite=1 -> next cycle M_exeOut=0x1234; cycle after: wb_data=0x1234, wb_rd=3, wb_regwrite=1.
//  Load addr 0x100, ack after 3 waits, rdata=0xDEADBEEF -> stall high 5 cycles, mem_req high 4, then wb_data=0xDEADBEEF.
//  Store addr 0x200, data 0xCAFE, ack on first cycle -> mem_we=1, mem_wdata=0xCAFE, stall 2 cycles, wb_regwrite=0.
//  Load addr 0x103 -> no mem_req, mem_err=1 and sticky, wb_regwrite=0 for that op.
//  TIMEOUT=8, ack never asserted -> mem_req high exactly 8 cycles, mem_err=1, pipeline resumes.
//  rst asserted mid-REQ -> next cycle all outputs 0, FSM IDLE, stall=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM + MEM/WB registers with req/ack data-memory access, stall, timeout and forwarding.
module mem_stage #(
  parameter int TIMEOUT = 256,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [31:0]     exeOut,
  input  logic [31:0]     addrOut,
  input  logic [31:0]     RegData1_o,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            stall,
  output logic [31:0]     M_exeOut,
  output logic [RD_W-1:0] M_rd,
  output logic            M_regwrite,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_regwrite,
  output logic            mem_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic m_valid, m_regwrite, m_memread, m_memwrite, squash;
  logic [31:0] m_addr, m_wdata, rdata_q;
  logic [CW-1:0] cnt;
  logic mem_op, misaligned, timeout_hit;
  assign mem_op      = m_valid & (m_memread | m_memwrite);
  assign misaligned  = m_addr[1:0] != 2'b00;
  assign timeout_hit = cnt == CW'(TIMEOUT - 1);
  assign M_regwrite  = m_regwrite & m_valid;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // misaligned ops skip the request and retire squashed; ack beats a same-cycle timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = mem_op ? (misaligned ? DONE : REQ) : IDLE;
      REQ:     state_nx = (mem_ack || timeout_hit) ? DONE : REQ;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    mem_req   = state == REQ;
    stall     = (state == IDLE && mem_op) || mem_req;
    mem_we    = mem_req & m_memwrite & ~m_memread;
    mem_addr  = mem_req ? m_addr : '0;
    mem_wdata = mem_req ? m_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      M_exeOut   <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      M_rd       <= '0;
      m_regwrite <= 1'b0;
      m_memread  <= 1'b0;
      m_memwrite <= 1'b0;
    end else if (!stall) begin
      m_valid    <= ex_valid;
      M_exeOut   <= exeOut;
      m_addr     <= addrOut;
      m_wdata    <= RegData1_o;
      M_rd       <= ex_rd;
      m_regwrite <= ex_regwrite;
      m_memread  <= ex_memread;
      m_memwrite <= ex_memwrite;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      squash  <= 1'b0;
      rdata_q <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt <= (state == REQ) ? cnt + CW'(1) : '0;
      if (state == IDLE && mem_op) begin
        squash  <= misaligned;
        mem_err <= mem_err | misaligned;
      end
      if (state == REQ && mem_ack)
        rdata_q <= mem_rdata;
      if (state == REQ && !mem_ack && timeout_hit) begin
        squash  <= 1'b1;
        mem_err <= 1'b1;
      end
    end
  end
  // stalled cycles retire a bubble; DONE retires the memory op, otherwise EX/MEM passes through
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
    end else if (stall) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_valid    <= m_valid;
      wb_data     <= (state == DONE && m_memread) ? rdata_q : M_exeOut;
      wb_rd       <= M_rd;
      wb_regwrite <= m_regwrite & m_valid & ~(state == DONE && squash);
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a writeback scoreboard and a simple req/ack memory model.
module tb_mem_stage;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ex_regwrite = 0, ex_memread = 0, ex_memwrite = 0;
  logic [31:0] exeOut = 0, addrOut = 0, RegData1_o = 0;
  logic [4:0] ex_rd = 0;
  logic mem_req, mem_we, mem_ack = 0, stall, M_regwrite, wb_valid, wb_regwrite, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, M_exeOut, wb_data;
  logic [4:0] M_rd, wb_rd;
  typedef struct {logic [31:0] data; logic [4:0] rd; logic rw; bit chk_data;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int ack_wait = 0, rq = 0, stall_cnt = 0, req_cnt = 0;
  logic cap_we;
  logic [31:0] cap_addr, cap_wdata;

  mem_stage #(.TIMEOUT(8), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .exeOut(exeOut), .addrOut(addrOut),
    .RegData1_o(RegData1_o), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .M_exeOut(M_exeOut), .M_rd(M_rd), .M_regwrite(M_regwrite), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // memory model: acks after ack_wait idle request cycles; also tallies stall/request activity
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (mem_req) begin
      req_cnt++;
      cap_we = mem_we;
      cap_addr = mem_addr;
      cap_wdata = mem_wdata;
      mem_ack = (rq == ack_wait);
      rq++;
    end else begin
      mem_ack = 0;
      rq = 0;
    end
  end

  // writeback monitor
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, e.rw});
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic issue(input logic [31:0] exe, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    int n = 0;
    @(negedge clk);
    while (stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (stall) chk("issue_wait_timeout", 32'd1, 32'd0);
    ex_valid = 1; exeOut = exe; addrOut = addr; RegData1_o = wd;
    ex_rd = rd; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    @(posedge clk);
    #1;
    ex_valid = 0; ex_memread = 0; ex_memwrite = 0; ex_regwrite = 0;
    stall_cnt = 0; req_cnt = 0;
  endtask

  task automatic drain();
    repeat (15) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_mem_err", {31'd0, mem_err}, 0);
    chk("rst_M_exeOut", M_exeOut, 0);
    // ALU op: forwarding next cycle, writeback the cycle after
    q.push_back('{32'h1234, 5'd3, 1'b1, 1'b1});
    issue(32'h1234, 32'h0, 32'h0, 5'd3, 1, 0, 0);
    @(negedge clk);
    chk("fwd_M_exeOut", M_exeOut, 32'h1234);
    chk("fwd_M_rd", {27'd0, M_rd}, 3);
    chk("fwd_M_regwrite", {31'd0, M_regwrite}, 1);
    chk("alu_no_stall", {31'd0, stall}, 0);
    @(negedge clk);
    chk("alu_latency_wb_valid", {31'd0, wb_valid}, 1);
    drain();
    // load with 3 wait cycles
    ack_wait = 3; mem_rdata = 32'hDEAD_BEEF;
    q.push_back('{32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1});
    issue(32'h100, 32'h100, 32'h0, 5'd5, 1, 1, 0);
    drain();
    chk("load_stall_cycles", stall_cnt, 5);
    chk("load_req_cycles", req_cnt, 4);
    chk("load_we", {31'd0, cap_we}, 0);
    chk("load_addr", cap_addr, 32'h100);
    // store, ack on first request cycle
    ack_wait = 0;
    q.push_back('{32'h200, 5'd7, 1'b0, 1'b1});
    issue(32'h200, 32'h200, 32'hCAFE, 5'd7, 0, 0, 1);
    drain();
    chk("store_stall_cycles", stall_cnt, 2);
    chk("store_req_cycles", req_cnt, 1);
    chk("store_we", {31'd0, cap_we}, 1);
    chk("store_wdata", cap_wdata, 32'hCAFE);
    chk("store_addr", cap_addr, 32'h200);
    // timeout with TIMEOUT=8
    chk("pre_timeout_err", {31'd0, mem_err}, 0);
    ack_wait = 1000;
    q.push_back('{32'h0, 5'd6, 1'b0, 1'b0});
    issue(32'h300, 32'h300, 32'h0, 5'd6, 1, 1, 0);
    drain();
    chk("timeout_req_cycles", req_cnt, 8);
    chk("timeout_stall_cycles", stall_cnt, 9);
    chk("timeout_err", {31'd0, mem_err}, 1);
    q.push_back('{32'h55, 5'd2, 1'b1, 1'b1});
    issue(32'h55, 32'h0, 32'h0, 5'd2, 1, 0, 0);
    drain();
    // memread and memwrite together behave as a load
    ack_wait = 1; mem_rdata = 32'h1111_2222;
    q.push_back('{32'h1111_2222, 5'd8, 1'b1, 1'b1});
    issue(32'h400, 32'h400, 32'h9999, 5'd8, 1, 1, 1);
    drain();
    chk("rdwr_we", {31'd0, cap_we}, 0);
    chk("rdwr_req_cycles", req_cnt, 2);
    // reset while a request is outstanding
    ack_wait = 1000;
    issue(32'h500, 32'h500, 32'h0, 5'd9, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'd0, mem_req}, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_mem_req", {31'd0, mem_req}, 0);
    chk("midrst_stall", {31'd0, stall}, 0);
    chk("midrst_err", {31'd0, mem_err}, 0);
    chk("midrst_M_exeOut", M_exeOut, 0);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 0);
    drain();
    // misaligned load
    q.push_back('{32'h0, 5'd4, 1'b0, 1'b0});
    issue(32'h103, 32'h103, 32'h0, 5'd4, 1, 1, 0);
    drain();
    chk("misalign_req_cycles", req_cnt, 0);
    chk("misalign_err", {31'd0, mem_err}, 1);
    q.push_back('{32'h77, 5'd0, 1'b1, 1'b1});
    issue(32'h77, 32'h0, 32'h0, 5'd0, 1, 0, 0);
    drain();
    chk("err_sticky", {31'd0, mem_err}, 1);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
